rv32i_rsrv_sttn: RTL and testbench
==================================

// Module: rv32i_rsrv_sttn
// PURPOSE
//  Per-PU reservation station directly downstream of dispatch. Accepts a dispatched uop when i_pu_id==PU_ID,
//  holds it until both source operands are valid, and snoops the write-back bus to capture missing sources.
//  Issues the oldest ready entry to its PU via a valid/ready handshake. o_full feeds dispatch's i_rsrv_sttn_full[PU_ID].
// PARAMETERS
//  PU_ID        0                 PU index this station serves; compared against i_pu_id
//  NUM_ENTRIES  RSRV_STTN_DEPTH   entry count (pkg default 4, must be >=2)
// PORTS
//  clk                 in   1                     clock; single clock domain
//  rst                 in   1                     synchronous, active-high reset
//  i_dispatch          in   1                     dispatch request valid
//  i_pu_id             in   PU_ID_BW              target PU of the request
//  i_src1_value_vld    in   1                     src1 value present
//  i_src1_value        in   REG_FILE_BW           src1 value
//  i_src1_phys_rf_vld  in   1                     src1 pending on a tag
//  i_src1_phys_rf_tag  in   PHYS_REG_FILE_IDX_BW  src1 wake-up tag
//  i_src2_value_vld    in   1                     src2 value present (includes I-type imm)
//  i_src2_value        in   REG_FILE_BW           src2 value
//  i_src2_phys_rf_vld  in   1                     src2 pending on a tag
//  i_src2_phys_rf_tag  in   PHYS_REG_FILE_IDX_BW  src2 wake-up tag
//  i_dst_phys_rf_vld   in   1                     uop writes a dst
//  i_dst_phys_rf_tag   in   PHYS_REG_FILE_IDX_BW  dst tag
//  i_dst_arch_rf_idx   in   ARCH_REG_FILE_IDX_BW  dst arch index
//  i_imm               in   REG_FILE_BW           immediate (S-type offset)
//  i_rob_idx           in   ROB_IDX_BW            ROB entry index
//  i_rob_full          in   1                     ROB full; blocks allocation
//  i_write_back        in   1                     WB snoop valid
//  i_phys_rf_wr_idx    in   PHYS_REG_FILE_IDX_BW  WB tag
//  i_wdata             in   REG_FILE_BW           WB data
//  o_full              out  1                     no free entry
//  o_issue             out  1                     issue valid to PU
//  i_pu_rdy            in   1                     PU accepts issue
//  o_issue_src1/src2   out  REG_FILE_BW each      operand values
//  o_issue_imm         out  REG_FILE_BW           immediate
//  o_issue_dst_vld/tag out  1 / PHYS_..._IDX_BW   dst valid / tag
//  o_issue_dst_arch    out  ARCH_REG_FILE_IDX_BW  dst arch index
//  o_issue_rob_idx     out  ROB_IDX_BW            ROB index
// BEHAVIOUR
//  Reset: all entries invalid, age state cleared, o_full=0, o_issue=0. Payload outputs are don't-care while o_issue=0.
//  A reset asserted mid-operation drops all held uops. There is no flush port.
//  alloc = i_dispatch & i_pu_id==PU_ID & ~o_full & ~i_rob_full.
//    Alloc writes the lowest-index free entry at the clock edge. The entry becomes issue-eligible next cycle.
//  o_full = (valid count == NUM_ENTRIES), from registered state only. A same-cycle issue does not clear it (no bypass).
//  Src ready = value_vld. Each WB cycle, every valid entry with ~value_vld & phys_rf_vld & tag==i_phys_rf_wr_idx
//    sets value_vld=1 and value=i_wdata. The same compare applies to the uop being allocated in that cycle.
//    A src with neither vld bit set is treated as ready (unused operand).
//  WB wake-up is visible for issue one cycle later. There is no same-cycle WB->issue bypass.
//  Issue select: the oldest entry with both srcs ready, tracked by an NxN age matrix (set on alloc, cleared on free).
//    o_issue and its payload are combinational from registered entry state.
//    Payload is held stable while o_issue & ~i_pu_rdy. A newer entry never displaces the selected one mid-stall.
//  o_issue & i_pu_rdy frees the entry at the edge.
//  Simultaneous alloc and issue are both performed. An allocation cannot target the entry being freed that cycle.
//  Throughput: 1 alloc + 1 issue per cycle. Minimum latency dispatch->issue is 1 cycle.
// STRUCTURE
//  rv32i_pkg adds: RSRV_STTN_DEPTH, ROB_IDX_BW, and typedef rsrv_entry_t (vld, src1/src2 value_vld/phys_vld/tag/value,
//    dst_vld/tag/arch, imm, rob_idx).
//  Sub-module rv32i_rs_age_matrix(NUM_ENTRIES): alloc one-hot, free one-hot, ready vector -> oldest-ready one-hot.
//  Top level holds: entry array, WB compare, free-slot priority encoder, issue mux.
// TESTING
//  1 Dispatch PU_ID with both srcs valid (5, 7), i_pu_rdy=1 -> o_issue next cycle: src1=5, src2=7, rob_idx matches.
//  2 Dispatch src1 pending tag 12. WB tag 12 data 0xDEAD two cycles later -> o_issue the cycle after WB, src1=0xDEAD.
//  3 Fill 4 entries, all pending, i_pu_rdy=1 -> o_full=1 and a fifth dispatch is ignored.
//    Wake entry 2 -> issued; o_full drops the cycle after.
//  4 Entries A (older) and B (newer) both ready, i_pu_rdy=0 for 3 cycles -> A held stable, then A issues, then B.
//  5 Full station, same cycle issue + dispatch -> dispatch rejected (o_full=1). Next cycle dispatch accepted into freed slot.
//  6 rst asserted with 3 valid entries -> next cycle o_issue=0, o_full=0, no stale issue afterward.
//    Also: i_pu_id != PU_ID and i_rob_full=1 both -> no allocation.

Source files
------------

// File: rtl/rv32i_rsrv_sttn_pkg.sv
// Shared widths, entry layout and operand helpers for the per-PU reservation station.
package rv32i_rsrv_sttn_pkg;

   localparam int REG_FILE_BW          = 32;
   localparam int PHYS_REG_FILE_IDX_BW = 6;
   localparam int ARCH_REG_FILE_IDX_BW = 5;
   localparam int PU_ID_BW             = 2;
   localparam int ROB_IDX_BW           = 5;
   localparam int RSRV_STTN_DEPTH      = 4;

   typedef struct packed {
      logic                            value_vld;
      logic                            phys_vld;
      logic [PHYS_REG_FILE_IDX_BW-1:0] tag;
      logic [REG_FILE_BW-1:0]          value;
   } rs_src_t;

   typedef struct packed {
      logic                            vld;
      rs_src_t                         src1;
      rs_src_t                         src2;
      logic                            dst_vld;
      logic [PHYS_REG_FILE_IDX_BW-1:0] dst_tag;
      logic [ARCH_REG_FILE_IDX_BW-1:0] dst_arch;
      logic [REG_FILE_BW-1:0]          imm;
      logic [ROB_IDX_BW-1:0]           rob_idx;
   } rsrv_entry_t;

   // An operand with neither valid bit set is unused and never blocks issue.
   function automatic logic src_rdy(input rs_src_t s);
      return s.value_vld | ~s.phys_vld;
   endfunction

   function automatic rs_src_t src_snoop(input rs_src_t s, input logic wb,
                                         input logic [PHYS_REG_FILE_IDX_BW-1:0] wb_tag,
                                         input logic [REG_FILE_BW-1:0] wb_data);
      rs_src_t r;
      r = s;
      if (wb && !s.value_vld && s.phys_vld && (s.tag == wb_tag)) begin
         r.value_vld = 1'b1;
         r.value     = wb_data;
      end
      return r;
   endfunction

endpackage

// File: rtl/rv32i_rsrv_sttn_age_matrix.sv
// Age matrix: age_q[i][j]=1 means entry i was allocated before entry j.
// Picks the oldest entry among those flagged ready.
module rv32i_rs_age_matrix #(
   parameter int NUM_ENTRIES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_ENTRIES-1:0] alloc_oh_i,
   input  logic [NUM_ENTRIES-1:0] free_oh_i,
   input  logic [NUM_ENTRIES-1:0] rdy_i,
   output logic [NUM_ENTRIES-1:0] oldest_o
);

   logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_q, age_d;

   // A new entry is younger than everything present; a freed entry drops out of both row and column.
   always_comb begin
      age_d = age_q;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (alloc_oh_i[i])
               age_d[i][j] = 1'b0;
            else if (alloc_oh_i[j])
               age_d[i][j] = 1'b1;
            if (free_oh_i[i] || free_oh_i[j])
               age_d[i][j] = 1'b0;
            if (i == j)
               age_d[i][j] = 1'b0;
         end
      end
   end

   always_comb begin
      logic blk;
      oldest_o = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         blk = 1'b0;
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (rdy_i[j] && age_q[j][i])
               blk = 1'b1;
         end
         oldest_o[i] = rdy_i[i] & ~blk;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         age_q <= '0;
      else
         age_q <= age_d;
   end

endmodule

// File: rtl/rv32i_rsrv_sttn.sv
// Per-PU reservation station: holds dispatched uops until operands arrive via write-back snoop,
// then issues the oldest ready entry over a valid/ready handshake.
module rv32i_rsrv_sttn
   import rv32i_rsrv_sttn_pkg::*;
#(
   parameter int PU_ID       = 0,
   parameter int NUM_ENTRIES = RSRV_STTN_DEPTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_dispatch,
   input  logic [PU_ID_BW-1:0]             i_pu_id,
   input  logic                            i_src1_value_vld,
   input  logic [REG_FILE_BW-1:0]          i_src1_value,
   input  logic                            i_src1_phys_rf_vld,
   input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_src1_phys_rf_tag,
   input  logic                            i_src2_value_vld,
   input  logic [REG_FILE_BW-1:0]          i_src2_value,
   input  logic                            i_src2_phys_rf_vld,
   input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_src2_phys_rf_tag,
   input  logic                            i_dst_phys_rf_vld,
   input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_dst_phys_rf_tag,
   input  logic [ARCH_REG_FILE_IDX_BW-1:0] i_dst_arch_rf_idx,
   input  logic [REG_FILE_BW-1:0]          i_imm,
   input  logic [ROB_IDX_BW-1:0]           i_rob_idx,
   input  logic                            i_rob_full,
   input  logic                            i_write_back,
   input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_phys_rf_wr_idx,
   input  logic [REG_FILE_BW-1:0]          i_wdata,
   output logic                            o_full,
   output logic                            o_issue,
   input  logic                            i_pu_rdy,
   output logic [REG_FILE_BW-1:0]          o_issue_src1,
   output logic [REG_FILE_BW-1:0]          o_issue_src2,
   output logic [REG_FILE_BW-1:0]          o_issue_imm,
   output logic                            o_issue_dst_vld,
   output logic [PHYS_REG_FILE_IDX_BW-1:0] o_issue_dst_tag,
   output logic [ARCH_REG_FILE_IDX_BW-1:0] o_issue_dst_arch,
   output logic [ROB_IDX_BW-1:0]           o_issue_rob_idx
);

   localparam logic [PU_ID_BW-1:0] PU_ID_L = PU_ID_BW'(PU_ID);

   rsrv_entry_t            entries_q [NUM_ENTRIES];
   rsrv_entry_t            entries_d [NUM_ENTRIES];
   rsrv_entry_t            new_entry;
   logic [NUM_ENTRIES-1:0] vld, rdy, free_slot_oh, alloc_oh, oldest_oh, sel_oh, free_oh;
   logic [NUM_ENTRIES-1:0] stall_sel_q, stall_sel_d;
   logic                   stall_q, stall_d;
   logic                   alloc;

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         vld[i] = entries_q[i].vld;
         rdy[i] = entries_q[i].vld & src_rdy(entries_q[i].src1) & src_rdy(entries_q[i].src2);
      end
   end

   assign o_full = &vld;
   assign alloc  = i_dispatch & (i_pu_id == PU_ID_L) & ~o_full & ~i_rob_full;

   // Only slots free in registered state are candidates, so the slot being issued is never reused this cycle.
   always_comb begin
      logic found;
      found        = 1'b0;
      free_slot_oh = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!vld[i] && !found) begin
            free_slot_oh[i] = 1'b1;
            found           = 1'b1;
         end
      end
   end

   assign alloc_oh = free_slot_oh & {NUM_ENTRIES{alloc}};

   always_comb begin
      new_entry                = '0;
      new_entry.vld            = 1'b1;
      new_entry.src1.value_vld = i_src1_value_vld;
      new_entry.src1.phys_vld  = i_src1_phys_rf_vld;
      new_entry.src1.tag       = i_src1_phys_rf_tag;
      new_entry.src1.value     = i_src1_value;
      new_entry.src2.value_vld = i_src2_value_vld;
      new_entry.src2.phys_vld  = i_src2_phys_rf_vld;
      new_entry.src2.tag       = i_src2_phys_rf_tag;
      new_entry.src2.value     = i_src2_value;
      new_entry.src1           = src_snoop(new_entry.src1, i_write_back, i_phys_rf_wr_idx, i_wdata);
      new_entry.src2           = src_snoop(new_entry.src2, i_write_back, i_phys_rf_wr_idx, i_wdata);
      new_entry.dst_vld        = i_dst_phys_rf_vld;
      new_entry.dst_tag        = i_dst_phys_rf_tag;
      new_entry.dst_arch       = i_dst_arch_rf_idx;
      new_entry.imm            = i_imm;
      new_entry.rob_idx        = i_rob_idx;
   end

   rv32i_rs_age_matrix #(
      .NUM_ENTRIES (NUM_ENTRIES)
   ) u_age (
      .clk        (clk),
      .rst        (rst),
      .alloc_oh_i (alloc_oh),
      .free_oh_i  (free_oh),
      .rdy_i      (rdy),
      .oldest_o   (oldest_oh)
   );

   // A stalled selection is pinned so an entry woken later cannot swap the payload under the PU.
   assign sel_oh      = stall_q ? stall_sel_q : oldest_oh;
   assign o_issue     = |sel_oh;
   assign free_oh     = sel_oh & {NUM_ENTRIES{i_pu_rdy}};
   assign stall_d     = o_issue & ~i_pu_rdy;
   assign stall_sel_d = sel_oh;

   always_comb begin
      o_issue_src1     = '0;
      o_issue_src2     = '0;
      o_issue_imm      = '0;
      o_issue_dst_vld  = 1'b0;
      o_issue_dst_tag  = '0;
      o_issue_dst_arch = '0;
      o_issue_rob_idx  = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (sel_oh[i]) begin
            o_issue_src1     = entries_q[i].src1.value;
            o_issue_src2     = entries_q[i].src2.value;
            o_issue_imm      = entries_q[i].imm;
            o_issue_dst_vld  = entries_q[i].dst_vld;
            o_issue_dst_tag  = entries_q[i].dst_tag;
            o_issue_dst_arch = entries_q[i].dst_arch;
            o_issue_rob_idx  = entries_q[i].rob_idx;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         entries_d[i]      = entries_q[i];
         entries_d[i].src1 = src_snoop(entries_q[i].src1, i_write_back, i_phys_rf_wr_idx, i_wdata);
         entries_d[i].src2 = src_snoop(entries_q[i].src2, i_write_back, i_phys_rf_wr_idx, i_wdata);
         if (free_oh[i])
            entries_d[i].vld = 1'b0;
         if (alloc_oh[i])
            entries_d[i] = new_entry;
      end
   end

   always_ff @(posedge clk) begin
      entries_q   <= entries_d;
      stall_sel_q <= stall_sel_d;
      if (rst) begin
         stall_q <= 1'b0;
         for (int i = 0; i < NUM_ENTRIES; i++)
            entries_q[i].vld <= 1'b0;
      end else begin
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_rv32i_rsrv_sttn.sv
// Directed, table-driven bench for the reservation station (PU_ID 0, four entries).
module tb_rv32i_rsrv_sttn;
   import rv32i_rsrv_sttn_pkg::*;

   typedef struct {
      logic        disp;
      logic [1:0]  pid;
      logic        s1v;
      logic [31:0] s1;
      logic [5:0]  s1tag;
      logic [31:0] s2;
      logic [4:0]  rob;
      logic        robf;
      logic        wb;
      logic [5:0]  wbtag;
      logic [31:0] wdata;
      logic        rdy;
      logic        e_iss;
      logic        e_full;
      logic [31:0] e_s1;
      logic [31:0] e_s2;
      logic [4:0]  e_rob;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_dispatch, i_src1_value_vld, i_src1_phys_rf_vld, i_src2_value_vld, i_src2_phys_rf_vld;
   logic [1:0]  i_pu_id;
   logic [31:0] i_src1_value, i_src2_value, i_imm, i_wdata;
   logic [5:0]  i_src1_phys_rf_tag, i_src2_phys_rf_tag, i_dst_phys_rf_tag, i_phys_rf_wr_idx;
   logic        i_dst_phys_rf_vld, i_rob_full, i_write_back, i_pu_rdy;
   logic [4:0]  i_dst_arch_rf_idx, i_rob_idx;
   logic        o_full, o_issue, o_issue_dst_vld;
   logic [31:0] o_issue_src1, o_issue_src2, o_issue_imm;
   logic [5:0]  o_issue_dst_tag;
   logic [4:0]  o_issue_dst_arch, o_issue_rob_idx;

   int n_chk  = 0;
   int n_fail = 0;
   vec_t tbl [24];

   always #5 clk = ~clk;

   rv32i_rsrv_sttn #(.PU_ID(0), .NUM_ENTRIES(4)) dut (
      .clk(clk), .rst(rst),
      .i_dispatch(i_dispatch), .i_pu_id(i_pu_id),
      .i_src1_value_vld(i_src1_value_vld), .i_src1_value(i_src1_value),
      .i_src1_phys_rf_vld(i_src1_phys_rf_vld), .i_src1_phys_rf_tag(i_src1_phys_rf_tag),
      .i_src2_value_vld(i_src2_value_vld), .i_src2_value(i_src2_value),
      .i_src2_phys_rf_vld(i_src2_phys_rf_vld), .i_src2_phys_rf_tag(i_src2_phys_rf_tag),
      .i_dst_phys_rf_vld(i_dst_phys_rf_vld), .i_dst_phys_rf_tag(i_dst_phys_rf_tag),
      .i_dst_arch_rf_idx(i_dst_arch_rf_idx), .i_imm(i_imm), .i_rob_idx(i_rob_idx),
      .i_rob_full(i_rob_full), .i_write_back(i_write_back),
      .i_phys_rf_wr_idx(i_phys_rf_wr_idx), .i_wdata(i_wdata),
      .o_full(o_full), .o_issue(o_issue), .i_pu_rdy(i_pu_rdy),
      .o_issue_src1(o_issue_src1), .o_issue_src2(o_issue_src2), .o_issue_imm(o_issue_imm),
      .o_issue_dst_vld(o_issue_dst_vld), .o_issue_dst_tag(o_issue_dst_tag),
      .o_issue_dst_arch(o_issue_dst_arch), .o_issue_rob_idx(o_issue_rob_idx)
   );

   function automatic vec_t mk(input int disp, input int pid, input int s1v, input int s1,
                               input int s1tag, input int s2, input int rob, input int robf,
                               input int wb, input int wbtag, input int wdata, input int rdy,
                               input int e_iss, input int e_full, input int e_s1, input int e_s2,
                               input int e_rob);
      vec_t v;
      v.disp = 1'(disp);   v.pid = 2'(pid);       v.s1v = 1'(s1v);     v.s1 = 32'(s1);
      v.s1tag = 6'(s1tag); v.s2 = 32'(s2);        v.rob = 5'(rob);     v.robf = 1'(robf);
      v.wb = 1'(wb);       v.wbtag = 6'(wbtag);   v.wdata = 32'(wdata); v.rdy = 1'(rdy);
      v.e_iss = 1'(e_iss); v.e_full = 1'(e_full); v.e_s1 = 32'(e_s1);   v.e_s2 = 32'(e_s2);
      v.e_rob = 5'(e_rob);
      return v;
   endfunction

   function automatic vec_t idle(input int rdy, input int e_iss, input int e_full,
                                 input int e_s1, input int e_s2, input int e_rob);
      return mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, rdy, e_iss, e_full, e_s1, e_s2, e_rob);
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v, input logic r);
      rst                = r;
      i_dispatch         = v.disp;
      i_pu_id            = v.pid;
      i_src1_value_vld   = v.s1v;
      i_src1_value       = v.s1;
      i_src1_phys_rf_vld = ~v.s1v;
      i_src1_phys_rf_tag = v.s1tag;
      i_src2_value_vld   = 1'b1;
      i_src2_value       = v.s2;
      i_src2_phys_rf_vld = 1'b0;
      i_src2_phys_rf_tag = '0;
      i_dst_phys_rf_vld  = 1'b1;
      i_dst_phys_rf_tag  = {1'b0, v.rob};
      i_dst_arch_rf_idx  = v.rob;
      i_imm              = 32'h1000 + 32'(v.rob);
      i_rob_idx          = v.rob;
      i_rob_full         = v.robf;
      i_write_back       = v.wb;
      i_phys_rf_wr_idx   = v.wbtag;
      i_wdata            = v.wdata;
      i_pu_rdy           = v.rdy;
   endtask

   // Outputs depend only on registered state, so they are checked mid-cycle after driving.
   task automatic step(input vec_t v, input string nm, input logic r);
      @(negedge clk);
      drive(v, r);
      #1;
      cmp({nm, "_issue"}, 32'(o_issue), 32'(v.e_iss));
      cmp({nm, "_full"}, 32'(o_full), 32'(v.e_full));
      if (v.e_iss) begin
         cmp({nm, "_src1"}, o_issue_src1, v.e_s1);
         cmp({nm, "_src2"}, o_issue_src2, v.e_s2);
         cmp({nm, "_rob"}, 32'(o_issue_rob_idx), 32'(v.e_rob));
         cmp({nm, "_imm"}, o_issue_imm, 32'h1000 + 32'(v.e_rob));
         cmp({nm, "_dst"}, {25'd0, o_issue_dst_vld, o_issue_dst_tag}, {26'd1, 1'b0, v.e_rob});
      end
   endtask

   initial begin
      // basic issue, WB wake-up, fill/full, full with same-cycle issue+dispatch, filtered dispatches
      tbl[0]  = mk(1, 0, 1, 5, 0, 7, 1, 0, 0, 0, 0, 1,        0, 0, 0, 0, 0);
      tbl[1]  = idle(1,                                       1, 0, 5, 7, 1);
      tbl[2]  = idle(1,                                       0, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 0, 0, 12, 3, 2, 0, 0, 0, 0, 1,       0, 0, 0, 0, 0);
      tbl[4]  = idle(1,                                       0, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 12, 'hDEAD, 1,  0, 0, 0, 0, 0);
      tbl[6]  = idle(1,                                       1, 0, 'hDEAD, 3, 2);
      tbl[7]  = idle(1,                                       0, 0, 0, 0, 0);
      tbl[8]  = mk(1, 0, 0, 0, 20, 'h10, 3, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0);
      tbl[9]  = mk(1, 0, 0, 0, 21, 'h11, 4, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0);
      tbl[10] = mk(1, 0, 0, 0, 22, 'h12, 5, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0);
      tbl[11] = mk(1, 0, 0, 0, 23, 'h13, 6, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0);
      tbl[12] = mk(1, 0, 0, 0, 24, 'h14, 7, 0, 0, 0, 0, 1,    0, 1, 0, 0, 0);
      tbl[13] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 22, 'h222, 1,   0, 1, 0, 0, 0);
      tbl[14] = idle(1,                                       1, 1, 'h222, 'h12, 5);
      tbl[15] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 24, 'h444, 1,   0, 0, 0, 0, 0);
      tbl[16] = mk(1, 0, 0, 0, 25, 'h15, 8, 0, 0, 0, 0, 1,    0, 0, 0, 0, 0);
      tbl[17] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 20, 'h200, 0,   0, 1, 0, 0, 0);
      tbl[18] = mk(1, 0, 1, 'h55, 0, 'h66, 9, 0, 0, 0, 0, 1,  1, 1, 'h200, 'h10, 3);
      tbl[19] = mk(1, 0, 1, 'h77, 0, 'h88, 10, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      tbl[20] = idle(1,                                       1, 1, 'h77, 'h88, 10);
      tbl[21] = mk(1, 1, 1, 'h99, 0, 'h9A, 13, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      tbl[22] = mk(1, 0, 1, 'hAA, 0, 'hAB, 14, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      tbl[23] = idle(1,                                       0, 0, 0, 0, 0);

      drive(idle(0, 0, 0, 0, 0, 0), 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      cmp("reset_issue", 32'(o_issue), 32'd0);
      cmp("reset_full", 32'(o_full), 32'd0);

      for (int k = 0; k < 24; k++)
         step(tbl[k], $sformatf("v%0d", k), 1'b0);

      // reset with three pending entries, wake-ups during/after reset must not resurrect them
      step(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 21, 'h121, 1, 0, 0, 0, 0, 0), "rst0", 1'b1);
      step(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 23, 'h123, 1, 0, 0, 0, 0, 0), "rst1", 1'b0);
      step(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 25, 'h125, 1, 0, 0, 0, 0, 0), "rst2", 1'b0);
      step(idle(1, 0, 0, 0, 0, 0), "rst3", 1'b0);

      // older A held through a 3-cycle stall while newer B is also ready, then A, then B
      step(mk(1, 0, 1, 'hA1, 0, 'hA2, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "stl0", 1'b0);
      step(mk(1, 0, 1, 'hB1, 0, 'hB2, 12, 0, 0, 0, 0, 0, 1, 0, 'hA1, 'hA2, 11), "stl1", 1'b0);
      step(idle(0, 1, 0, 'hA1, 'hA2, 11), "stl2", 1'b0);
      step(idle(0, 1, 0, 'hA1, 'hA2, 11), "stl3", 1'b0);
      step(idle(1, 1, 0, 'hA1, 'hA2, 11), "stl4", 1'b0);
      step(idle(1, 1, 0, 'hB1, 'hB2, 12), "stl5", 1'b0);
      step(idle(1, 0, 0, 0, 0, 0), "stl6", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
